sdf_stage4: RTL
===============

# sdf_stage4

Radix-2 single-path delay-feedback (SDF) butterfly stage with a 4-deep feedback delay line, operating on 24-bit complex fixed-point samples (Q.8, 256 = 1.0). It sits directly downstream of the 8-point-period twiddle/state generator for this stage and consumes its `state`, `w_r` and `w_i` outputs in the same cycle. Each input sample is either stored, summed with its partner, or its stored difference is rotated by the twiddle. The result is a registered stream for the next FFT stage.

## Interface
- `DW`, default 24: sample and twiddle component width, two's complement.
- `FRAC`, default 8: twiddle fractional bits; products are arithmetic-shifted right by this amount.
- `DEPTH`, default 4: feedback delay length, fixed to 4 for this stage.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input sample qualifier; also the stage advance enable.
- `din_r`, `din_i` in DW: input sample, real/imag.
- `state` in 2: phase from the twiddle generator. 0 = fill, 1 = butterfly, 2 = twiddle multiply. 3 is never driven.
- `w_r`, `w_i` in DW: twiddle for the current cycle, Q.8.
- `out_valid` out 1: output qualifier.
- `dout_r`, `dout_i` out DW: output sample, registered.

## Operation
- Delay line: 4 complex entries, FIFO order. `head` is the oldest entry.
- The line shifts by one only on cycles with `in_valid`=1. On all other cycles it holds.
- Per `in_valid` cycle, the action depends on `state`:
  - state 0 (fill): push din; no output (`out_valid` next = 0).
  - state 1 (butterfly): output head+din; push head−din.
  - state 2 (rotate): output head×W; push din.
- Sums and differences are DW bits and wrap modulo 2^DW. No saturation, no growth.
- Complex multiply:
  - re = (h_r·w_r − h_i·w_i) >>> FRAC
  - im = (h_r·w_i + h_i·w_r) >>> FRAC
  - Use full-precision 2·DW products, an arithmetic shift (truncation toward −∞), then take the low DW bits.
- Steady stream, per 8-sample frame x0..x7:
  - Outputs: x0+x4, x1+x5, x2+x6, x3+x7, then (x0−x4)·W0 … (x3−x7)·W3.
  - Twiddles: W0=256, W1=181−j181, W2=−j256, W3=−181−j181.
  - While the second half is output, the next frame's first half is being pushed.
- Upstream contract:
  - After the first `in_valid`, `in_valid` stays high contiguously, because the twiddle generator advances its phase counter every cycle.
  - The final 4 rotated outputs are drained by 4 extra `in_valid` cycles carrying zero data.
- `state`=3 with `in_valid`=1: treated as fill (push din, no output). Never legitimately occurs.

## Timing
- Reset (async assert): all 4 delay entries = 0, `dout_r`=`dout_i`=0, `out_valid`=0. Removal is synchronous to `clk` by design of the surrounding system.
- Latency: the output for the input accepted in cycle t appears registered in cycle t+1.
- First valid output: 5 cycles after x0 is accepted (x4 accepted at t=4, x0+x4 visible at t=5).
- `out_valid`(t+1) = `in_valid`(t) AND `state`(t) ∈ {1,2}.
- When `out_valid`=0, `dout` holds its last value.
- Reset mid-frame: all contents are discarded immediately. The next accepted sample is treated per the (also reset) generator, starting at fill.
- No backpressure: a downstream stage must accept every `out_valid` cycle.

## Test plan
- Impulse: x=[256,0,0,0,0,0,0,0] then 4 zeros.
  - Output: 256, 0, 0, 0, 256, 0, 0, 0 (imag all 0).
  - `out_valid` rises exactly 5 cycles after x0.
- DC: 8 samples of 256+j0 then 4 zeros.
  - Output: 512 ×4, then 0 ×4.
- Twiddle W1 check: x1=256, all others 0.
  - Output: 0, 256, 0, 0, 0, 181−j181, 0, 0.
- Wrap: x0=x4=0x7FFFFF, others 0.
  - First output `dout_r`=0xFFFFFE.
  - Fifth output `dout_r`=0, `dout_i`=0.
- Reset mid-frame: assert `rst_n`=0 after x2.
  - `dout`=0 and `out_valid`=0 asynchronously.
  - A fresh impulse afterward reproduces the impulse scenario exactly.
- Streaming: two back-to-back frames (impulse, then DC) with no gap.
  - Outputs: 256,0,0,0, then 256,0,0,0 interleaved correctly with 512×4, then 0×4.
  - `out_valid` stays continuously high.

Source files
------------

// File: rtl/sdf_stage4.sv
// Radix-2 SDF butterfly stage with a 4-deep feedback delay line.
// Each accepted sample is stored, summed with its partner, or its stored difference is rotated.
module sdf_stage4 #(
  parameter int DW    = 24,
  parameter int FRAC  = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] din_r,
  input  logic [DW-1:0] din_i,
  input  logic [1:0]    state,
  input  logic [DW-1:0] w_r,
  input  logic [DW-1:0] w_i,
  output logic          out_valid,
  output logic [DW-1:0] dout_r,
  output logic [DW-1:0] dout_i
);

  typedef enum logic [1:0] {
    PH_FILL  = 2'd0,
    PH_BFLY  = 2'd1,
    PH_ROT   = 2'd2,
    PH_SPARE = 2'd3
  } phase_e;

  phase_e phase;
  assign phase = phase_e'(state);

  logic [DW-1:0] line_r [DEPTH];
  logic [DW-1:0] line_i [DEPTH];
  logic [DW-1:0] head_r, head_i;

  assign head_r = line_r[DEPTH-1];
  assign head_i = line_i[DEPTH-1];

  logic [DW-1:0] sum_r, sum_i, diff_r, diff_i;
  assign sum_r  = head_r + din_r;
  assign sum_i  = head_i + din_i;
  assign diff_r = head_r - din_r;
  assign diff_i = head_i - din_i;

  // Full-precision products; the shift floors toward minus infinity before truncation.
  logic signed [2*DW-1:0] p_rr, p_ii, p_ri, p_ir, acc_r, acc_i;
  assign p_rr  = $signed(head_r) * $signed(w_r);
  assign p_ii  = $signed(head_i) * $signed(w_i);
  assign p_ri  = $signed(head_r) * $signed(w_i);
  assign p_ir  = $signed(head_i) * $signed(w_r);
  assign acc_r = p_rr - p_ii;
  assign acc_i = p_ri + p_ir;

  logic [DW-1:0] rot_r, rot_i;
  assign rot_r = DW'(acc_r >>> FRAC);
  assign rot_i = DW'(acc_i >>> FRAC);

  logic [DW-1:0] push_r, push_i;
  logic          emit;

  always_comb begin
    push_r = din_r;
    push_i = din_i;
    emit   = 1'b0;
    case (phase)
      PH_BFLY: begin
        push_r = diff_r;
        push_i = diff_i;
        emit   = 1'b1;
      end
      PH_ROT:  emit = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        line_r[k] <= '0;
        line_i[k] <= '0;
      end
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
    end else begin
      out_valid <= in_valid && emit;
      if (in_valid) begin
        for (int k = DEPTH-1; k > 0; k--) begin
          line_r[k] <= line_r[k-1];
          line_i[k] <= line_i[k-1];
        end
        line_r[0] <= push_r;
        line_i[0] <= push_i;
        if (phase == PH_BFLY) begin
          dout_r <= sum_r;
          dout_i <= sum_i;
        end else if (phase == PH_ROT) begin
          dout_r <= rot_r;
          dout_i <= rot_i;
        end
      end
    end
  end

endmodule
